main_fsm: RTL and testbench

//  Moore sequencer for the multicycle ARM datapath. Steps every instruction through

---
 rtl/main_fsm_pkg.sv | 40 ++++
 rtl/main_fsm_outdec.sv | 75 +++++++
 rtl/main_fsm.sv | 116 +++++++++++
 tb/tb_main_fsm.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/main_fsm_pkg.sv
// Shared state encodings and datapath mux select codes for the multicycle ARM sequencer.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_UNDEF  = 4'd10,
    S_FAULT  = 4'd11
  } state_t;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RM     = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // States that stall on the memory handshake and therefore run the wait counter.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Pure combinational state -> control decode; only IRWrite/NextPC also look at MemReady.
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  logic [3:0] state,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Undef,
  output logic       dec_fault
);

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_RN;
    ALUSrcB   = SRCB_RM;
    ResultSrc = RES_ALUOUT;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    Undef     = 1'b0;
    dec_fault = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECR:  ALUOp = 1'b1;
      S_EXECI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      S_ALUWB:  RegW = 1'b1;
      S_BRANCH: begin
        ALUSrcA   = SRCA_ALUOUT;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        Branch    = 1'b1;
      end
      S_UNDEF:  Undef = 1'b1;
      // FAULT and every unused encoding: all enables off.
      default:  dec_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Moore sequencer for the multicycle ARM datapath; counts retired instructions.
// Latency: one state per cycle; EXECI A00 B01 ALUOp1; ->ALUWB.
// Backpressure: FETCH/MEMRD/MEMWR hold on MemReady and go to FAULT after TIMEOUT waits.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             NextPC,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic             Undef,
  output logic             Fault,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstRet
);

  localparam int WAIT_W = $clog2(TIMEOUT);

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fault_q;
  logic              dec_fault;
  logic              waiting;
  logic              timed_out;
  logic              retire;
  logic              funct_unused;

  // Only the I and S/L bits of Funct steer the sequencer.
  assign funct_unused = ^Funct[4:1];

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    waiting   = is_wait_state(state_q);
    timed_out = waiting && !MemReady && (wait_cnt == WAIT_W'(TIMEOUT - 1));
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNDEF;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWR: begin
        if (MemReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_UNDEF: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
    // A ready in the final wait cycle already moved us on; only a silent memory faults.
    if (timed_out) state_d = S_FAULT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      InstRet  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (waiting && (state_d == state_q)) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                 wait_cnt <= '0;
      if (retire) InstRet <= InstRet + CNT_W'(1);
      if (state_d == S_FAULT) fault_q <= 1'b1;
    end
  end

  main_fsm_outdec u_outdec (
    .state     (state_q),
    .MemReady  (MemReady),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .Undef     (Undef),
    .dec_fault (dec_fault)
  );

  assign Fault = fault_q | dec_fault;
  assign State = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: each stimulus cycle queues the expected outputs, a monitor compares mid-cycle.
module tb_main_fsm;
  import main_fsm_pkg::*;

  localparam int TIMEOUT = 6;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic             MemReady;
  logic             IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch, Undef, Fault;
  logic [1:0]       ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstRet;

  typedef struct packed {
    logic [3:0]       st;
    logic             ir;
    logic             adr;
    logic [1:0]       a;
    logic [1:0]       b;
    logic [1:0]       res;
    logic             aluop;
    logic             npc;
    logic             regw;
    logic             memw;
    logic             br;
    logic             undef;
    logic             fault;
    logic [CNT_W-1:0] ret;
  } obs_t;

  obs_t             sb[$];
  string            tags[$];
  int               n_chk  = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] exp_ret   = '0;
  logic             exp_fault = 1'b0;

  main_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .Undef(Undef), .Fault(Fault), .State(State), .InstRet(InstRet)
  );

  always #5 clk = ~clk;

  // Expected controls for a state, written straight from the state table.
  function automatic obs_t ctl(input state_t st, input logic mr);
    obs_t c;
    c = '0;
    c.st = st;
    case (st)
      S_FETCH:  begin c.a = 2'b01; c.b = 2'b10; c.res = 2'b10; c.ir = mr; c.npc = mr; end
      S_DECODE: begin c.a = 2'b01; c.b = 2'b10; c.res = 2'b10; end
      S_MEMADR: begin c.a = 2'b00; c.b = 2'b01; end
      S_MEMRD:  begin c.adr = 1'b1; c.res = 2'b00; end
      S_MEMWB:  begin c.res = 2'b01; c.regw = 1'b1; end
      S_MEMWR:  begin c.adr = 1'b1; c.memw = 1'b1; end
      S_EXECR:  begin c.b = 2'b00; c.aluop = 1'b1; end
      S_EXECI:  begin c.b = 2'b01; c.aluop = 1'b1; end
      S_ALUWB:  c.regw = 1'b1;
      S_BRANCH: begin c.a = 2'b10; c.b = 2'b01; c.res = 2'b10; c.br = 1'b1; end
      S_UNDEF:  c.undef = 1'b1;
      default:  c.fault = 1'b1;
    endcase
    return c;
  endfunction

  task automatic cyc(input string tag, input state_t st, input logic [1:0] op,
                     input logic [5:0] fn, input logic mr);
    obs_t e;
    Op = op; Funct = fn; MemReady = mr;
    e = ctl(st, mr);
    e.ret   = exp_ret;
    e.fault = exp_fault;
    sb.push_back(e);
    tags.push_back(tag);
    @(posedge clk); #1;
  endtask

  task automatic do_branch(input string tag);
    cyc({tag, "_fetch"}, S_FETCH, 2'b10, 6'd0, 1'b1);
    cyc({tag, "_decode"}, S_DECODE, 2'b10, 6'd0, 1'b0);
    cyc({tag, "_branch"}, S_BRANCH, 2'b10, 6'd0, 1'b0);
    exp_ret = exp_ret + 1'b1;
  endtask

  // Monitor: the sequencer presents a full control word every cycle.
  initial begin
    obs_t  e, o;
    string t;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        t = tags.pop_front();
        o = '{st: State, ir: IRWrite, adr: AdrSrc, a: ALUSrcA, b: ALUSrcB, res: ResultSrc,
              aluop: ALUOp, npc: NextPC, regw: RegW, memw: MemW, br: Branch, undef: Undef,
              fault: Fault, ret: InstRet};
        n_chk++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL %s: got st=%0d ctl=%h ret=%0d, expected st=%0d ctl=%h ret=%0d",
                   t, o.st, o, o.ret, e.st, e, e.ret);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; Op = 2'b00; Funct = 6'd0; MemReady = 1'b0;
    @(posedge clk); #1;
    cyc("reset_state", S_FETCH, 2'b00, 6'd0, 1'b0);
    reset = 1'b1;

    // ADD register form
    cyc("add_fetch", S_FETCH, 2'b00, 6'b001000, 1'b1);
    cyc("add_decode", S_DECODE, 2'b00, 6'b001000, 1'b0);
    cyc("add_execr", S_EXECR, 2'b00, 6'b001000, 1'b0);
    cyc("add_aluwb", S_ALUWB, 2'b00, 6'b001000, 1'b0);
    exp_ret = exp_ret + 1'b1;

    // ADD immediate form, with a two-cycle fetch stall
    cyc("addi_fetch_stall0", S_FETCH, 2'b00, 6'b101000, 1'b0);
    cyc("addi_fetch_stall1", S_FETCH, 2'b00, 6'b101000, 1'b0);
    cyc("addi_fetch", S_FETCH, 2'b00, 6'b101000, 1'b1);
    cyc("addi_decode", S_DECODE, 2'b00, 6'b101000, 1'b0);
    cyc("addi_execi", S_EXECI, 2'b00, 6'b101000, 1'b0);
    cyc("addi_aluwb", S_ALUWB, 2'b00, 6'b101000, 1'b0);
    exp_ret = exp_ret + 1'b1;

    // LDR with three wait cycles in MEMRD
    cyc("ldr_fetch", S_FETCH, 2'b01, 6'b000001, 1'b1);
    cyc("ldr_decode", S_DECODE, 2'b01, 6'b000001, 1'b0);
    cyc("ldr_memadr", S_MEMADR, 2'b01, 6'b000001, 1'b0);
    for (int i = 0; i < 3; i++) cyc("ldr_memrd_wait", S_MEMRD, 2'b01, 6'b000001, 1'b0);
    cyc("ldr_memrd_ready", S_MEMRD, 2'b01, 6'b000001, 1'b1);
    cyc("ldr_memwb", S_MEMWB, 2'b01, 6'b000001, 1'b0);
    exp_ret = exp_ret + 1'b1;

    // Branch, then undefined opcode
    do_branch("b");
    cyc("undef_fetch", S_FETCH, 2'b11, 6'd0, 1'b1);
    cyc("undef_decode", S_DECODE, 2'b11, 6'd0, 1'b0);
    cyc("undef_pulse", S_UNDEF, 2'b11, 6'd0, 1'b0);
    exp_ret = exp_ret + 1'b1;

    // STR completing after one wait
    cyc("str_fetch", S_FETCH, 2'b01, 6'b000000, 1'b1);
    cyc("str_decode", S_DECODE, 2'b01, 6'b000000, 1'b0);
    cyc("str_memadr", S_MEMADR, 2'b01, 6'b000000, 1'b0);
    cyc("str_memwr_wait", S_MEMWR, 2'b01, 6'b000000, 1'b0);
    cyc("str_memwr_ready", S_MEMWR, 2'b01, 6'b000000, 1'b1);
    exp_ret = exp_ret + 1'b1;

    // LDR where MemReady arrives in the very last wait cycle: ready wins
    cyc("ldrlate_fetch", S_FETCH, 2'b01, 6'b000001, 1'b1);
    cyc("ldrlate_decode", S_DECODE, 2'b01, 6'b000001, 1'b0);
    cyc("ldrlate_memadr", S_MEMADR, 2'b01, 6'b000001, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++)
      cyc("ldrlate_memrd_wait", S_MEMRD, 2'b01, 6'b000001, 1'b0);
    cyc("ldrlate_ready_wins", S_MEMRD, 2'b01, 6'b000001, 1'b1);
    cyc("ldrlate_memwb", S_MEMWB, 2'b01, 6'b000001, 1'b0);
    exp_ret = exp_ret + 1'b1;

    // Enough branches to carry InstRet through 15 -> 0
    for (int i = 0; i < 16; i++) do_branch("wrap");
    cyc("wrap_after", S_FETCH, 2'b00, 6'd0, 1'b0);

    // Asynchronous reset in the middle of a store
    cyc("rst_fetch", S_FETCH, 2'b01, 6'b000000, 1'b1);
    cyc("rst_decode", S_DECODE, 2'b01, 6'b000000, 1'b0);
    cyc("rst_memadr", S_MEMADR, 2'b01, 6'b000000, 1'b0);
    cyc("rst_memwr", S_MEMWR, 2'b01, 6'b000000, 1'b0);
    reset = 1'b0;
    exp_ret = '0;
    cyc("rst_async_fetch", S_FETCH, 2'b01, 6'b000000, 1'b0);
    reset = 1'b1;

    // STR that never completes: MemW held TIMEOUT cycles, then FAULT
    cyc("to_fetch", S_FETCH, 2'b01, 6'b000000, 1'b1);
    cyc("to_decode", S_DECODE, 2'b01, 6'b000000, 1'b0);
    cyc("to_memadr", S_MEMADR, 2'b01, 6'b000000, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) cyc("to_memwr_wait", S_MEMWR, 2'b01, 6'b000000, 1'b0);
    exp_fault = 1'b1;
    for (int i = 0; i < 3; i++) cyc("fault_absorb", S_FAULT, 2'b01, 6'b000000, 1'b1);

    // Reset clears the sticky fault
    reset = 1'b0;
    exp_fault = 1'b0;
    exp_ret = '0;
    cyc("fault_reset", S_FETCH, 2'b00, 6'd0, 1'b0);
    reset = 1'b1;
    do_branch("post_reset");
    cyc("post_reset_fetch", S_FETCH, 2'b00, 6'd0, 1'b0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
